// File: rtl/keypoint_uart_tx.sv
// Byte FIFO feeding a UART transmitter for the keypoint result stream (8N1, or 8E1 with parity).
// Latency: byte pushed in cycle 0 is popped in cycle 1; the start bit appears on tx in cycle 2.
// Backpressure: none upstream; bytes arriving while the FIFO is full are dropped and overflow sticks high.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   in_valid, in_data byte stream from the keypoint detector (no ready)
//   tx                registered UART line, idle high
//   busy              registered: FIFO non-empty or frame in progress (one cycle lag)
//   fifo_full         FIFO holds FIFO_DEPTH entries
//   overflow          sticky drop flag, cleared only by rst
//   fifo_count        FIFO occupancy, 0..FIFO_DEPTH
//
// Build option: define KEYPOINT_TX_PARITY_EN to insert an even-parity bit after the data bits.

module keypoint_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_count
);

  // Baud counter only needs to reach CLKS_PER_BIT-1, independent of FIFO sizing.
  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef KEYPOINT_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push;
  logic              pop;
  logic [7:0]        head;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // does not rescue a byte arriving while full.
  assign push = in_valid && (count < DEPTH_C);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_count = count;
  assign fifo_full  = (count == DEPTH_C);

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_n;
  logic [7:0]        shift;
  logic [7:0]        shift_n;
  logic              tx_q;
  logic              tx_n;
  logic              busy_q;
  logic              baud_done;
`ifdef KEYPOINT_TX_PARITY_EN
  logic              par_q;
  logic              par_n;
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    pop     = 1'b0;
`ifdef KEYPOINT_TX_PARITY_EN
    par_n   = par_q;
`endif

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = head;
          bit_n   = '0;
          baud_n  = '0;
          state_n = START;
`ifdef KEYPOINT_TX_PARITY_EN
          // Captured at load because the shift register is drained by the parity slot.
          par_n   = ^head;
`endif
        end
      end

      START: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
`ifdef KEYPOINT_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

`ifdef KEYPOINT_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase

    // Line level is decided from the state being entered, then registered,
    // so tx changes exactly at the state boundary and never glitches.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef KEYPOINT_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef KEYPOINT_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
      busy_q   <= (state != IDLE) || (count != '0);
`ifdef KEYPOINT_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_keypoint_uart_tx.sv
// Bench for keypoint_uart_tx: frame-level reference model compared every cycle,
// a serial-line receiver decoding tx, and literal cycle-exact expectations.

module tb_keypoint_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef KEYPOINT_TX_PARITY_EN
  localparam int NSLOT = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NSLOT = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int LEN     = NSLOT * CPB;
  localparam int LOGN    = 8192;
  localparam int T_STOP  = 2 + (NSLOT - 1) * CPB;   // first stop cycle of a frame started by a cycle-0 push
  localparam int T_BUSY0 = T_STOP + CPB + 1;        // busy low cycle after that frame

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          tx;
  logic          busy;
  logic          fifo_full;
  logic          overflow;
  logic [AW:0]   fifo_count;

  keypoint_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of accepted bytes and a position within the frame.
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  int         fpos  = -1;
  logic [7:0] cur   = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_busy = 1'b0;

  function automatic logic line_level(input int pos, input logic [7:0] b);
    int slot;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR && slot == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int sz0;
    sz0 = mq.size();
    if (rst) begin
      mq.delete();
      fpos   = -1;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_busy = (fpos >= 0) || (sz0 != 0);
      if (fpos >= 0) begin
        if (fpos == LEN - 1) fpos = -1;
        else fpos++;
      end else if (sz0 != 0) begin
        cur  = mq.pop_front();
        fpos = 0;
      end
      if (in_valid) begin
        if (sz0 < DEPTH) mq.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, waveform log and serial receiver (sampled mid-cycle).
  // ---------------------------------------------------------------------------
  logic       tx_log   [LOGN];
  logic       busy_log [LOGN];
  logic       full_log [LOGN];
  logic       ovf_log  [LOGN];
  logic [4:0] cnt_log  [LOGN];

  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  int         rx_pos = -1;
  logic [7:0] rx_sh  = 8'h00;

  always @(negedge clk) begin : compare
    int slot;
    logic exp_tx;
    if (started) begin
      exp_tx = (fpos < 0) ? 1'b1 : line_level(fpos, cur);
      chk("tx",         32'(tx),         32'(exp_tx));
      chk("busy",       32'(busy),       32'(m_busy));
      chk("fifo_count", 32'(fifo_count), mq.size());
      chk("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      if (cyc < LOGN) begin
        tx_log[cyc]   = tx;
        busy_log[cyc] = busy;
        full_log[cyc] = fifo_full;
        ovf_log[cyc]  = overflow;
        cnt_log[cyc]  = fifo_count;
      end

      if (rst) begin
        rx_pos = -1;
      end else if (rx_pos < 0) begin
        if (tx == 1'b0) begin
          rx_pos = 0;
          rx_sh  = 8'h00;
        end
      end else begin
        rx_pos++;
        if (rx_pos % CPB == CPB / 2) begin
          slot = rx_pos / CPB;
          if (slot >= 1 && slot <= 8) rx_sh[slot-1] = tx;
          if (PAR && slot == 9) rx_par_q.push_back(tx);
          if (slot == NSLOT - 1) begin
            chk("rx_stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(rx_sh);
            rx_pos = -1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic chk_log(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  int         k0;
  int         base;
  logic [7:0] a5_bits;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    started = 1'b1;
    rst     = 1'b0;
    tick();

    // Reset state
    @(negedge clk);
    chk("reset_tx",    32'(tx),         32'd1);
    chk("reset_busy",  32'(busy),       32'd0);
    chk("reset_full",  32'(fifo_full),  32'd0);
    chk("reset_ovf",   32'(overflow),   32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    tick();

    // Single byte 0xA5: start low 2..5, data LSB first from 6, stop, busy low afterwards.
    k0   = cyc;
    base = rx_q.size();
    push(8'hA5);
    repeat (60) tick();
    a5_bits = 8'b1010_0101;
    chk("a5_count_c1", 32'(cnt_log[k0+1]), 32'd1);
    chk("a5_count_c2", 32'(cnt_log[k0+2]), 32'd0);
    chk_log("a5_tx_c1", tx_log[k0+1], 1'b1);
    chk_log("a5_tx_c2", tx_log[k0+2], 1'b0);
    chk_log("a5_tx_c5", tx_log[k0+5], 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_log("a5_bit_first", tx_log[k0+6+CPB*i],       a5_bits[i]);
      chk_log("a5_bit_last",  tx_log[k0+6+CPB*i+CPB-1], a5_bits[i]);
    end
    chk_log("a5_stop_first", tx_log[k0+T_STOP], 1'b1);
    chk_log("a5_busy_c2",    busy_log[k0+2], 1'b1);
    chk_log("a5_busy_last",  busy_log[k0+T_BUSY0-1], 1'b1);
    chk_log("a5_busy_fall",  busy_log[k0+T_BUSY0], 1'b0);
    chk("a5_rx_n", rx_q.size() - base, 32'd1);
    chk("a5_rx",   32'(rx_q[base]), 32'hA5);

    // Back-to-back 0x00, 0xFF: stop + one idle cycle of high line, then start.
    k0   = cyc;
    base = rx_q.size();
    push(8'h00);
    push(8'hFF);
    repeat (2 * LEN + 20) tick();
    for (int i = 0; i < CPB + 1; i++) chk_log("gap_high", tx_log[k0+T_STOP+i], 1'b1);
    chk_log("gap_start2", tx_log[k0+T_STOP+CPB+1], 1'b0);
    chk("b2b_rx_n", rx_q.size() - base, 32'd2);
    chk("b2b_rx0",  32'(rx_q[base]),   32'h00);
    chk("b2b_rx1",  32'(rx_q[base+1]), 32'hFF);

    // Push during the pop at fifo_count=5: occupancy holds, nothing lost.
    k0   = cyc;
    base = rx_q.size();
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    repeat (2 + LEN - 6) tick();
    push(8'h46);
    repeat (7 * (LEN + 1) + 20) tick();
    chk("pp_count_before", 32'(cnt_log[k0+2+LEN]), 32'd5);
    chk("pp_count_after",  32'(cnt_log[k0+3+LEN]), 32'd5);
    chk("pp_rx_n", rx_q.size() - base, 32'd7);
    for (int i = 0; i < 7; i++) chk("pp_rx", 32'(rx_q[base+i]), 32'h40 + i);

    // 20 consecutive pushes into a 16-deep FIFO: 0..16 sent, 17..19 dropped.
    k0   = cyc;
    base = rx_q.size();
    for (int i = 0; i < 20; i++) push(8'(i));
    repeat (17 * (LEN + 1) + 20) tick();
    chk_log("ovf_full_c16", full_log[k0+16], 1'b0);
    chk_log("ovf_full_c17", full_log[k0+17], 1'b1);
    chk_log("ovf_flag_c17", ovf_log[k0+17], 1'b0);
    chk_log("ovf_flag_c18", ovf_log[k0+18], 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_idle_busy", 32'(busy), 32'd0);
    chk("ovf_rx_n", rx_q.size() - base, 32'd17);
    for (int i = 0; i < 17; i++) chk("ovf_rx", 32'(rx_q[base+i]), i);

    // Reset during DATA of 0x3C with three more queued.
    do_reset();
    tick();
    k0   = cyc;
    base = rx_q.size();
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx",    32'(tx),         32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    repeat (150) tick();
    chk("rst_count_c4", 32'(cnt_log[k0+4]), 32'd3);
    chk_log("rst_tx_c100", tx_log[k0+100], 1'b1);
    chk("rst_no_frames", rx_q.size() - base, 32'd0);

`ifdef KEYPOINT_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0, 44-cycle frames.
    k0   = cyc;
    base = rx_par_q.size();
    push(8'h07);
    push(8'h03);
    repeat (2 * LEN + 20) tick();
    chk_log("par_bit0",    tx_log[k0+2+36], 1'b1);
    chk_log("par_stop_end", tx_log[k0+45], 1'b1);
    chk_log("par_idle",    tx_log[k0+46], 1'b1);
    chk_log("par_start2",  tx_log[k0+47], 1'b0);
    chk_log("par_bit1",    tx_log[k0+47+36], 1'b0);
    chk("par_rx_n", rx_par_q.size() - base, 32'd2);
    chk("par_rx0",  32'(rx_par_q[base]),   32'd1);
    chk("par_rx1",  32'(rx_par_q[base+1]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypoint_uart_tx.md
# keypoint_uart_tx

Serial transmitter for the keypoint result stream. It accepts the byte-wide valid/data stream emitted by the keypoint detector (`keypoint_valid`/`Dout`) and buffers it in a FIFO. It then sends each byte off-chip as a standard asynchronous UART frame. It is the hardware counterpart of the simulation-only display sink and sits at the end of the camera → grayscale → filter → keypoint pipeline.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held; legal range is ≥2.
- `FIFO_DEPTH`, default 16: entries in the byte FIFO; must be a power of two.
- `ADDR_W`, default 4: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — the byte on `in_data` is presented this cycle; there is no backpressure.
- `in_data`  in  8  — keypoint byte.
- `tx`  out  1  — UART line; idle level is high.
- `busy`  out  1  — high while the FIFO is non-empty or a frame is in progress.
- `fifo_full`  out  1  — FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  — sticky flag; set when a byte is dropped.
- `fifo_count`  out  ADDR_W+1  — current FIFO occupancy.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `overflow`=0, `fifo_count`=0. The FSM resets to IDLE and the FIFO pointers reset to 0.
- Push rule: when `in_valid`=1 and the registered count is less than `FIFO_DEPTH`, the byte is written at the clock edge.
  - When the FIFO is full, the byte is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle.
  - `overflow` clears only on `rst`.
- Simultaneous push and pop (FIFO not full): both take effect, so `fifo_count` is unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START. Otherwise stay in IDLE.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits, LSB first, each bit for `CLKS_PER_BIT` cycles. After bit 7 go to PARITY or STOP.
  - PARITY: `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- IDLE always lasts at least 1 cycle between frames. Back-to-back frames therefore have a stop interval of `CLKS_PER_BIT`+1 cycles.
- The baud counter is ADDR-independent, sized to hold `CLKS_PER_BIT`−1, and resets to 0 at every state entry.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` ranges from 0 to `FIFO_DEPTH` inclusive.
- `tx` is driven from a register, so it is glitch-free.
- Reset mid-frame: the frame is aborted, `tx` is 1 in the cycle after the reset edge, and the FIFO contents are discarded.

## Timing
- Latency: if `in_valid` is asserted in cycle 0 while the block is in IDLE with an empty FIFO, then:
  - the byte is written at the end of cycle 0;
  - the pop happens in cycle 1 (`fifo_count` returns to 0 in cycle 2);
  - `tx` falls in cycle 2.
- Frame length: 10·`CLKS_PER_BIT` cycles (11·`CLKS_PER_BIT` with parity).
- `busy` is registered and follows occupancy/state with one cycle of lag. It deasserts in the cycle after STOP ends, provided the FIFO is empty.
- `fifo_full` and `fifo_count` reflect occupancy after the previous edge.

## Configuration
- The macro `KEYPOINT_TX_PARITY_EN` controls parity.
  - Defined: the PARITY state is present and an even-parity bit follows the data. The frame is 8E1, 11·`CLKS_PER_BIT` cycles.
  - Undefined: there is no PARITY state, logic, or register. The frame is 8N1, 10·`CLKS_PER_BIT` cycles.

## Test plan
- Single byte 0xA5 with `CLKS_PER_BIT`=4, no parity, pulsed in cycle 0 → `tx` low in cycles 2–5; data bits 1,0,1,0,0,1,0,1 in 4-cycle slots from cycle 6; high from cycle 38; `busy` falls in cycle 43.
- 20 consecutive `in_valid` cycles with data 0..19 and `FIFO_DEPTH`=16 → bytes 0..16 are transmitted in order; bytes 17–19 are dropped; `overflow`=1 from cycle 18 onward; `fifo_full`=1 in cycle 17.
- Two bytes 0x00 and 0xFF back to back → the gap between the first stop start and the second start bit is exactly 5 cycles; the line stays high throughout that gap.
- `rst` asserted during the DATA state of byte 0x3C with 3 bytes queued → `tx`=1 and `fifo_count`=0 next cycle; no further frames are sent; `overflow` is 0.
- With `KEYPOINT_TX_PARITY_EN` defined, send 0x07 then 0x03 → parity bits are 1 then 0; each frame is 44 cycles.
- Push while popping at `fifo_count`=5 → `fifo_count` stays 5 and no data is lost.
